// File: rtl/cpu_uart_tx.sv
// cpu_uart_tx: memory-mapped 8N1 UART transmitter on the CPU data bus.
//   Stores to TXDATA go into a FIFO. An FSM drains the FIFO LSB first on tx.
//   Optional macro UART_TX_PARITY_EN adds the CTRL register at 0xC and a
//   parity bit between the data bits and the stop bit.
// Ports:
//   clk, rst_n  system clock, asynchronous active-low reset
//   sel         UART window selected by the external address decoder
//   addr[3:0]   byte offset within the window; only addr[3:2] is decoded
//   wdata[31:0] store data
//   we[3:0]     byte write enables
//   rdata[31:0] combinational read data (0 when not selected)
//   tx          registered serial output, idle high
//   busy        frame in progress or FIFO non-empty
module cpu_uart_tx #(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [15:0] DIV_RESET  = 16'd433
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sel,
    input  logic [3:0]  addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  we,
    output logic [31:0] rdata,
    output logic        tx,
    output logic        busy
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW:0]   wr_ptr_q, rd_ptr_q, level;
    logic          full, empty, avail, pop, enq_ok;
    logic          wr, wr_txdata, wr_status, wr_div;
    logic [7:0]    pop_data;
    logic [15:0]   div_q;
    logic          ovf_q;

    state_t        state_q, state_d;
    logic [15:0]   cnt_q, cnt_d, shadow_q, shadow_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          bit_end, load;
    logic          par_en_q, par_en_d, par_q, par_d;

    logic          unused_bits;
    assign unused_bits = ^{wdata[31:16], addr[1:0], we[3:2]};

    // Write decode
    assign wr        = sel && (we != 4'b0000);
    assign wr_txdata = wr && (addr[3:2] == 2'd0) && we[0];
    assign wr_status = wr && (addr[3:2] == 2'd1) && we[0] && wdata[3];
    assign wr_div    = wr && (addr[3:2] == 2'd2);

    // FIFO status
    assign level = wr_ptr_q - rd_ptr_q;
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (level == (AW+1)'(FIFO_DEPTH));

    // An enqueue into an empty FIFO is forwarded straight to the shifter so
    // the start bit appears the cycle after the write edge; both pointers
    // advance together and the FIFO stays empty.
    assign avail    = !empty || wr_txdata;
    assign pop_data = empty ? wdata[7:0] : mem_q[rd_ptr_q[AW-1:0]];
    assign enq_ok   = wr_txdata && (!full || pop);

    always_ff @(posedge clk) begin
        if (enq_ok) mem_q[wr_ptr_q[AW-1:0]] <= wdata[7:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
            div_q    <= DIV_RESET;
        end else begin
            if (enq_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)    rd_ptr_q <= rd_ptr_q + 1'b1;
            if (wr_txdata && !enq_ok) ovf_q <= 1'b1;
            else if (wr_status)       ovf_q <= 1'b0;
            if (wr_div && we[0]) div_q[7:0]  <= wdata[7:0];
            if (wr_div && we[1]) div_q[15:8] <= wdata[15:8];
        end
    end

`ifdef UART_TX_PARITY_EN
    logic [1:0] ctrl_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                   ctrl_q <= '0;
        else if (wr && (addr[3:2] == 2'd3) && we[0]) ctrl_q <= wdata[1:0];
    end
`endif

    // Transmit FSM
    assign bit_end = (cnt_q == shadow_q);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        par_en_d = par_en_q;
        par_d    = par_q;
        load     = 1'b0;
        pop      = 1'b0;
        if (state_q != S_IDLE) cnt_d = bit_end ? '0 : cnt_q + 16'd1;
        case (state_q)
            S_IDLE:  if (avail) load = 1'b1;
            S_START: if (bit_end) begin
                state_d = S_DATA;
                bit_d   = '0;
            end
            S_DATA:  if (bit_end) begin
                shift_d = shift_q >> 1;
                bit_d   = bit_q + 3'd1;
                if (bit_q == 3'd7) state_d = par_en_q ? S_PARITY : S_STOP;
            end
            S_PARITY: if (bit_end) state_d = S_STOP;
            S_STOP:  if (bit_end) begin
                if (avail) load = 1'b1;
                else       state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (load) begin
            pop      = 1'b1;
            shift_d  = pop_data;
            shadow_d = div_q;
            cnt_d    = '0;
            state_d  = S_START;
`ifdef UART_TX_PARITY_EN
            par_en_d = ctrl_q[0];
            par_d    = (^pop_data) ^ ctrl_q[1];
`else
            par_en_d = 1'b0;
            par_d    = 1'b0;
`endif
        end
        // tx is registered from the next-state values so it changes with the state.
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
            S_PARITY: tx_d = par_d;
            default:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            shadow_q <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
            par_en_q <= 1'b0;
            par_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
            par_en_q <= par_en_d;
            par_q    <= par_d;
        end
    end

    assign tx   = tx_q;
    assign busy = (state_q != S_IDLE) || !empty;

    // Read mux: side-effect free
    always_comb begin
        rdata = '0;
        if (sel) begin
            case (addr[3:2])
                2'd1: rdata = {20'd0, 4'(level), 4'd0, ovf_q, (state_q != S_IDLE), empty, full};
                2'd2: rdata = {16'd0, div_q};
`ifdef UART_TX_PARITY_EN
                2'd3: rdata = {30'd0, ctrl_q};
`endif
                default: rdata = '0;
            endcase
        end
    end
endmodule

// File: tb/tb_cpu_uart_tx.sv
module tb_cpu_uart_tx;
    logic        clk, rst_n, sel;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  we;
    logic [31:0] rdata;
    logic        tx, busy;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    int unsigned cyc = 0;
    int unsigned last_end = 0;
    bit          mon_en = 0;
    bit          mon_busy = 0;

    typedef struct {
        logic [10:0] bits;
        int unsigned nb;
        int unsigned bl;
        bit          b2b;
    } frame_t;
    frame_t exp_q[$];

    cpu_uart_tx #(.FIFO_DEPTH(8), .DIV_RESET(16'd433)) dut (
        .clk(clk), .rst_n(rst_n), .sel(sel), .addr(addr), .wdata(wdata),
        .we(we), .rdata(rdata), .tx(tx), .busy(busy)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] w);
        sel = 1; addr = a; wdata = d; we = w;
        @(posedge clk); #1;
        sel = 0; addr = '0; wdata = '0; we = '0;
    endtask

    task automatic bus_read(input string name, input logic [3:0] a, input logic [31:0] exp);
        @(negedge clk);
        sel = 1; addr = a; we = '0;
        #1 check(name, rdata, exp);
        sel = 0; addr = '0;
    endtask

    task automatic push_frame(input logic [7:0] d, input int unsigned bl, input bit b2b);
        exp_q.push_back('{bits: {2'b01, d, 1'b0}, nb: 10, bl: bl, b2b: b2b});
    endtask

    task automatic push_par_frame(input logic [7:0] d, input logic p, input int unsigned bl);
        exp_q.push_back('{bits: {1'b1, p, d, 1'b0}, nb: 11, bl: bl, b2b: 1'b0});
    endtask

    task automatic wait_idle(input string name, input int unsigned bound);
        int unsigned n = 0;
        @(negedge clk);
        while ((busy || mon_busy) && n < bound) begin
            @(negedge clk);
            n++;
        end
        check(name, (n < bound), 1);
        @(negedge clk);
    endtask

    // Frame monitor: detects a start bit, samples the whole frame and
    // compares it with the head of the expected-frame queue.
    initial begin : monitor
        frame_t      e;
        logic [10:0] got;
        logic        lvl;
        bit          stable, have;
        int unsigned start_cyc, prev_end;
        forever begin
            @(negedge clk);
            if (mon_en && rst_n && tx === 1'b0) begin
                mon_busy  = 1;
                start_cyc = cyc;
                have      = (exp_q.size() != 0);
                if (have) e = exp_q.pop_front();
                else      e = '{bits: '0, nb: 10, bl: 1, b2b: 1'b0};
                got    = '0;
                stable = 1;
                lvl    = 1'b0;
                for (int unsigned b = 0; b < e.nb; b++) begin
                    for (int unsigned c = 0; c < e.bl; c++) begin
                        if (b != 0 || c != 0) @(negedge clk);
                        if (c == 0) begin
                            lvl    = tx;
                            got[b] = tx;
                        end else if (tx !== lvl) begin
                            stable = 0;
                        end
                    end
                end
                prev_end = last_end;
                last_end = cyc;
                check("frame_expected", have, 1);
                if (have) begin
                    check("frame_bits", got, e.bits);
                    check("frame_bit_stable", stable, 1);
                    if (e.b2b) check("frame_no_gap", start_cyc, prev_end + 1);
                end
                mon_busy = 0;
            end
        end
    end

    initial begin : stim
        int unsigned n;
        rst_n = 0; sel = 0; addr = '0; wdata = '0; we = '0;
        repeat (2) @(negedge clk);
        check("reset_tx", tx, 1);
        check("reset_busy", busy, 0);
        rst_n = 1;
        bus_read("reset_status", 4'h4, 32'h002);
        bus_read("reset_divisor", 4'h8, 32'd433);
        bus_read("txdata_reads_zero", 4'h0, 32'h0);
        bus_read("reg_c_reads_zero", 4'hC, 32'h0);
        @(negedge clk); sel = 0; addr = 4'h8;
        #1 check("unselected_rdata", rdata, 32'h0);

        // 8N1 frame at DIVISOR=3
        @(negedge clk);
        bus_write(4'h8, 32'h3, 4'b0011);
        mon_en = 1;
        push_frame(8'h55, 4, 1'b0);
        bus_write(4'h0, 32'h55, 4'b0001);
        @(negedge clk);
        check("start_latency", tx, 0);
        n = 1;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("busy_drop_cycle", n, 41);
        wait_idle("idle_after_55", 100);

        // Back-to-back frames at DIVISOR=0
        bus_write(4'h8, 32'h0, 4'b0011);
        push_frame(8'hA5, 1, 1'b0);
        push_frame(8'h3C, 1, 1'b1);
        bus_write(4'h0, 32'hA5, 4'b0001);
        bus_write(4'h0, 32'h3C, 4'b0001);
        repeat (12) @(negedge clk);
        bus_read("status_after_second_pop", 4'h4, 32'h006);
        wait_idle("idle_after_b2b", 100);

        // Overflow with a stalled shifter
        mon_en = 0;
        bus_write(4'h8, 32'hFFFF, 4'b0011);
        bus_write(4'h0, 32'h11, 4'b0001);
        for (int unsigned i = 0; i < 9; i++) bus_write(4'h0, 32'h20 + i, 4'b0001);
        bus_read("status_full_ovf", 4'h4, 32'h80D);
        bus_write(4'h4, 32'h8, 4'b0001);
        bus_read("status_ovf_cleared", 4'h4, 32'h805);
        @(negedge clk); sel = 1; addr = 4'h4; we = '0;
        repeat (100) @(negedge clk);
        sel = 0;
        bus_read("status_after_hold", 4'h4, 32'h805);
        bus_write(4'h8, 32'h1200, 4'b0010);
        bus_read("divisor_byte_write", 4'h8, 32'h12FF);
        bus_read("divisor_offset_ignored", 4'hA, 32'h12FF);

        // Reset clears a stalled frame; then reset mid-data-bit
        @(negedge clk); rst_n = 0;
        @(negedge clk); rst_n = 1;
        bus_write(4'h8, 32'h3, 4'b0011);
        bus_write(4'h0, 32'hFF, 4'b0001);
        repeat (7) @(negedge clk);
        check("busy_mid_frame", busy, 1);
        #2 rst_n = 0;
        #1 check("async_reset_tx", tx, 1);
        check("async_reset_busy", busy, 0);
        bus_read("async_reset_status", 4'h4, 32'h002);
        bus_read("async_reset_divisor", 4'h8, 32'd433);
        @(negedge clk); rst_n = 1;

        // Frame at the reset divisor
        mon_en = 1;
        push_frame(8'h81, 434, 1'b0);
        bus_write(4'h0, 32'h81, 4'b0001);
        wait_idle("idle_after_81", 6000);

`ifdef UART_TX_PARITY_EN
        bus_write(4'h8, 32'h0, 4'b0011);
        bus_write(4'hC, 32'h1, 4'b0001);
        bus_read("ctrl_readback", 4'hC, 32'h1);
        push_par_frame(8'h07, 1'b1, 1);
        bus_write(4'h0, 32'h07, 4'b0001);
        wait_idle("idle_after_even_par", 100);
        bus_write(4'hC, 32'h3, 4'b0001);
        push_par_frame(8'h07, 1'b0, 1);
        bus_write(4'h0, 32'h07, 4'b0001);
        wait_idle("idle_after_odd_par", 100);
`endif

        check("frames_left", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
